// File: rtl/exe_muldiv_pkg.sv
// exe_muldiv_pkg: shared op encodings, FSM states and width defaults for the mul/div unit
package exe_muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int MD_OP_W  = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/exe_muldiv_md_core.sv
// exe_muldiv_md_core: radix-2 iterative datapath, shift-add multiply or restoring divide on magnitudes
module exe_muldiv_md_core
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic [2*XLEN-1:0] init_i,
    output logic [2*XLEN-1:0] acc_nxt_o,
    output logic              last_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d, step_val;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN:0]     sum, trial;

    // one step: multiply adds the multiplicand into the high half and shifts right;
    // divide shifts {rem,quo} left and keeps the trial subtraction when it does not borrow
    always_comb begin
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        step_val = div_q ? (trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                        : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                         : {sum, acc_q[XLEN-1:1]};
        acc_d    = load_i ? init_i : step_i ? step_val : acc_q;
        opnd_d   = load_i ? opnd_i : opnd_q;
        div_d    = load_i ? is_div_i : div_q;
        cnt_d    = load_i ? CW'(XLEN) : step_i ? cnt_q - 1'b1 : cnt_q;
    end

    // datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc_nxt_o = acc_d;
    assign last_o    = cnt_q == CW'(1);

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RV32M/RV64M execute unit with FSM, special cases, sign fix-up and stall/flush
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MUL_FAST = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [4:0]         reg_waddr_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               stall_o,
    output logic               done_o,
    output logic               reg_we_o,
    output logic [4:0]         reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d, op_in;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [XLEN-1:0]   res_q, res_d, wdata_q, wdata_d;
    logic              accept, sgn1, sgn2, n1, n2, is_div, div0, ovf, fast, load, step, last;
    logic [XLEN-1:0]   mag1, mag2, opnd, quo, rem;
    logic [2*XLEN-1:0] init, acc_nxt, prod;

    // decode the request: magnitudes, result signs, special cases and accumulator seed
    always_comb begin
        op_in     = md_op_e'(op_i);
        accept    = state_q == S_IDLE && start_i && !flush_i;
        sgn1      = op_in != MD_MULHU && op_in != MD_DIVU && op_in != MD_REMU;
        sgn2      = sgn1 && op_in != MD_MULHSU;
        n1        = sgn1 && op1_i[XLEN-1];
        n2        = sgn2 && op2_i[XLEN-1];
        mag1      = n1 ? -op1_i : op1_i;
        mag2      = n2 ? -op2_i : op2_i;
        is_div    = op_i[2];
        div0      = is_div && op2_i == '0;
        ovf       = is_div && sgn2 && op1_i == MIN_NEG && op2_i == '1;
        fast      = MUL_FAST != 0 && !is_div;
        init      = div0   ? {op1_i, {XLEN{1'b1}}}
                  : ovf    ? {{XLEN{1'b0}}, op1_i}
                  : fast   ? {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2}
                  : is_div ? {{XLEN{1'b0}}, mag1}
                  :          {{XLEN{1'b0}}, mag2};
        opnd      = is_div ? mag2 : mag1;
        op_d      = accept ? op_in : op_q;
        neg_res_d = accept ? !(div0 || ovf) && (n1 ^ n2) : neg_res_q;
        neg_rem_d = accept ? !(div0 || ovf) && is_div && n1 : neg_rem_q;
        waddr_d   = accept ? reg_waddr_i : waddr_q;
    end

    // next-state logic: special cases and fast multiply skip CALC, flush aborts to IDLE
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = (div0 || ovf || fast) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                step    = 1'b1;
                state_d = flush_i ? S_IDLE : last ? S_DONE : S_CALC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // sign fix-up and result select on the accumulator value entering DONE
    always_comb begin
        prod    = neg_res_d ? -acc_nxt : acc_nxt;
        quo     = neg_res_d ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem     = neg_rem_d ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        res_d   = state_d != S_DONE ? res_q
                : !op_d[2]          ? (op_d == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : op_d[1]           ? rem : quo;
        done_o  = state_q == S_DONE && !flush_i;
        wdata_d = done_o ? res_q : wdata_q;
    end

    // control and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= MD_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            waddr_q   <= '0;
            res_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            waddr_q   <= waddr_d;
            res_q     <= res_d;
            wdata_q   <= wdata_d;
        end
    end

    exe_muldiv_md_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (is_div),
        .opnd_i   (opnd),
        .init_i   (init),
        .acc_nxt_o(acc_nxt),
        .last_o   (last)
    );

    assign busy_o      = state_q != S_IDLE;
    assign stall_o     = accept || state_q == S_CALC;
    assign reg_we_o    = done_o;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = done_o ? res_q : wdata_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: table-driven and hand-sequenced checks of the iterative and fast mul/div units
module tb_exe_muldiv;
    import exe_muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, start_f, flush_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  reg_waddr_i;
    logic        busy_o, stall_o, done_o, reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        busy_f, stall_f, done_f, we_f;
    logic [4:0]  waddr_f;
    logic [31:0] wdata_f;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;

    exe_muldiv #(.XLEN(32), .MUL_FAST(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg_waddr_i(reg_waddr_i), .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );

    exe_muldiv #(.XLEN(32), .MUL_FAST(1)) dut_f (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_f), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg_waddr_i(reg_waddr_i), .flush_i(flush_i), .busy_o(busy_f), .stall_o(stall_f), .done_o(done_f),
        .reg_we_o(we_f), .reg_waddr_o(waddr_f), .reg_wdata_o(wdata_f)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; starts an op and follows it to its done pulse.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp, input int lat);
        int got = 0;
        int bad_stall = 0;
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; reg_waddr_i = wa;
        #1 chk({nm, " stall_on_start"}, 64'(stall_o), 64'd1);
        for (int k = 1; k <= 100 && got == 0; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o) begin
                got = k;
                chk({nm, " wdata"}, 64'(reg_wdata_o), 64'(exp));
                chk({nm, " waddr"}, 64'(reg_waddr_o), 64'(wa));
                chk({nm, " we"}, 64'(reg_we_o), 64'd1);
                chk({nm, " stall_in_done"}, 64'(stall_o), 64'd0);
            end else if (!stall_o) begin
                bad_stall++;
            end
        end
        chk({nm, " latency"}, 64'(got), 64'(lat));
        chk({nm, " stall_gaps"}, 64'(bad_stall), 64'd0);
        @(negedge clk_i);
        chk({nm, " done_pulse"}, 64'(done_o), 64'd0);
        chk({nm, " busy_after"}, 64'(busy_o), 64'd0);
        chk({nm, " wdata_held"}, 64'(reg_wdata_o), 64'(exp));
    endtask

    initial begin
        int seen_done;
        vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{MD_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{MD_MUL,    32'h12345678,   32'h00000010, 32'h23456780, 33};
        vecs[5]  = '{MD_MULHU,  32'h12345678,   32'h00000100, 32'h00000012, 33};
        vecs[6]  = '{MD_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        vecs[7]  = '{MD_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        vecs[8]  = '{MD_DIVU,   32'd100,        32'd7,        32'd14,       33};
        vecs[9]  = '{MD_REMU,   32'd100,        32'd7,        32'd2,        33};
        vecs[10] = '{MD_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[11] = '{MD_REM,    32'd5,          32'd0,        32'd5,        1};
        vecs[12] = '{MD_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{MD_REMU,   32'd5,          32'd0,        32'd5,        1};
        vecs[14] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[15] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};

        rst_i = 1'b1; start_i = 1'b0; start_f = 1'b0; flush_i = 1'b0;
        op_i = 3'd0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset we", 64'(reg_we_o), 64'd0);
        chk("reset waddr", 64'(reg_waddr_o), 64'd0);
        chk("reset wdata", 64'(reg_wdata_o), 64'd0);
        chk("reset stall", 64'(stall_o), 64'd0);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat);

        // start together with flush in IDLE is dropped
        start_i = 1'b1; flush_i = 1'b1; op_i = MD_DIVU; op1_i = 32'd9; op2_i = 32'd3; reg_waddr_i = 5'd30;
        #1 chk("start_flush stall", 64'(stall_o), 64'd0);
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        chk("start_flush busy", 64'(busy_o), 64'd0);
        chk("start_flush done", 64'(done_o), 64'd0);

        // flush at cycle 10 of a DIVU, then restart the very next cycle
        seen_done = 0;
        start_i = 1'b1; op_i = MD_DIVU; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd20;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o) seen_done++;
        end
        flush_i = 1'b1;
        #1 chk("flush stall_cycle10", 64'(stall_o), 64'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush busy", 64'(busy_o), 64'd0);
        chk("flush stall", 64'(stall_o), 64'd0);
        chk("flush no_done", 64'(seen_done + int'(done_o)), 64'd0);
        chk("flush wdata_kept", 64'(reg_wdata_o), 64'h0);
        run_op("after_flush", MD_DIV, 32'hFFFFFF9C, 32'd7, 5'd21, 32'hFFFFFFF2, 33);

        // reset in the middle of CALC
        start_i = 1'b1; op_i = MD_MUL; op1_i = 32'd7; op2_i = 32'd3; reg_waddr_i = 5'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("midcalc busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midcalc_rst busy", 64'(busy_o), 64'd0);
        chk("midcalc_rst done", 64'(done_o), 64'd0);
        chk("midcalc_rst we", 64'(reg_we_o), 64'd0);
        chk("midcalc_rst waddr", 64'(reg_waddr_o), 64'd0);
        chk("midcalc_rst wdata", 64'(reg_wdata_o), 64'd0);
        chk("midcalc_rst stall", 64'(stall_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // single-cycle multiply variant
        start_f = 1'b1; op_i = MD_MUL; op1_i = 32'd6; op2_i = 32'd7; reg_waddr_i = 5'd9;
        @(negedge clk_i);
        start_f = 1'b0;
        chk("fast done", 64'(done_f), 64'd1);
        chk("fast we", 64'(we_f), 64'd1);
        chk("fast wdata", 64'(wdata_f), 64'd42);
        chk("fast waddr", 64'(waddr_f), 64'd9);
        @(negedge clk_i);
        chk("fast done_pulse", 64'(done_f), 64'd0);
        chk("fast busy_after", 64'(busy_f), 64'd0);
        start_f = 1'b1; op_i = MD_MULH; op1_i = 32'hFFFFFFFF; op2_i = 32'hFFFFFFFF; reg_waddr_i = 5'd10;
        @(negedge clk_i);
        start_f = 1'b0;
        chk("fast mulh wdata", 64'(wdata_f), 64'h0);
        chk("fast mulh done", 64'(done_f), 64'd1);
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
